// File: rtl/imm_narrow.sv
// Narrows signed IN_W-bit values to a signed OUT_W-bit immediate field, with saturate/wrap
// overflow handling, a 2-entry in-order output buffer and a saturating overflow counter.
module imm_narrow #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  // Bits that must all equal the field's sign bit for the value to fit.
  logic [IN_W-OUT_W:0] upper_bits;
  logic                fits;
  logic [OUT_W-1:0]    sat_val;
  logic [OUT_W-1:0]    narrow_data;
  logic                narrow_ovf;

  assign upper_bits  = in_data[IN_W-1:OUT_W-1];
  assign fits        = (&upper_bits) | ~(|upper_bits);
  assign sat_val     = {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}};
  assign narrow_ovf  = ~fits;
  assign narrow_data = (narrow_ovf && sat_mode) ? sat_val : in_data[OUT_W-1:0];

  // The head entry lives directly in the output register so that out_data/out_ovf hold their
  // last value when the buffer drains; the second entry waits in the tail register.
  logic [1:0]       occ_q, occ_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic             head_ovf_q, head_ovf_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic             tail_ovf_q, tail_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_ovf   = head_ovf_q;
  assign ovf_count = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = narrow_data;
          head_ovf_d  = narrow_ovf;
        end else begin
          tail_data_d = narrow_data;
          tail_ovf_d  = narrow_ovf;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_ovf_d  = tail_ovf_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at occupancy 1: the new entry replaces the departing head.
        head_data_d = narrow_data;
        head_ovf_d  = narrow_ovf;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (push && narrow_ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      tail_data_q <= '0;
      tail_ovf_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      tail_data_q <= tail_data_d;
      tail_ovf_q  <= tail_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
